// File: rtl/aurora_rx_block_sorter.sv
// Lane block sorter: waits for lock and a first idle, then routes data blocks
// and user-K control blocks into separate FWFT FIFOs and counts malformed blocks.

module aurora_rx_block_sorter_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             valid_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty, pop, push;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full_o = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop  = rd_en_i && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push = wr_en_i && (!full_o || pop);

    assign valid_o   = !empty;
    assign rd_data_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
endmodule

// state      | meaning
// UNLOCKED   | lane not locked, everything discarded
// WAIT_IDLE  | locked, discarding until the first idle block
// RUN        | sorting blocks into data/cmd FIFOs
module aurora_rx_block_sorter #(
    parameter int         DATA_DEPTH = 16,
    parameter int         CMD_DEPTH  = 4,
    parameter logic [7:0] IDLE_BTF   = 8'h78,
    parameter logic [7:0] USERK_BTF  = 8'hD2
) (
    input  logic        clk_rx_i,
    input  logic        rst_n_i,
    input  logic [63:0] rx_data_i,
    input  logic [1:0]  rx_header_i,
    input  logic        rx_valid_i,
    input  logic        rx_locked_i,
    output logic [63:0] data_o,
    output logic        data_valid_o,
    input  logic        data_ready_i,
    output logic [55:0] cmd_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic        overflow_o,
    output logic [15:0] hdr_err_cnt_o,
    output logic [15:0] unk_btf_cnt_o,
    output logic [1:0]  state_o
);
    typedef enum logic [1:0] {
        ST_UNLOCKED  = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_RUN       = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        overflow_q, overflow_d;
    logic [15:0] hdr_err_q, hdr_err_d;
    logic [15:0] unk_btf_q, unk_btf_d;
    logic        data_wr, cmd_wr, hdr_inc, unk_inc;
    logic        data_full, cmd_full, data_pop, cmd_pop, flush;
    logic [7:0]  btf;

    assign btf      = rx_data_i[63:56];
    assign flush    = !rx_locked_i;
    assign data_pop = data_valid_o && data_ready_i && rx_locked_i;
    assign cmd_pop  = cmd_valid_o && cmd_ready_i && rx_locked_i;

    always_comb begin
        state_d = state_q;
        data_wr = 1'b0;
        cmd_wr  = 1'b0;
        hdr_inc = 1'b0;
        unk_inc = 1'b0;
        if (!rx_locked_i) begin
            state_d = ST_UNLOCKED;
        end else begin
            case (state_q)
                ST_UNLOCKED:  state_d = ST_WAIT_IDLE;
                ST_WAIT_IDLE: begin
                    if (rx_valid_i && rx_header_i == 2'b10 && btf == IDLE_BTF)
                        state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (rx_valid_i) begin
                        if (rx_header_i == 2'b01) begin
                            data_wr = 1'b1;
                        end else if (rx_header_i == 2'b10) begin
                            if (btf == USERK_BTF)     cmd_wr  = 1'b1;
                            else if (btf != IDLE_BTF) unk_inc = 1'b1;
                        end else begin
                            hdr_inc = 1'b1;
                        end
                    end
                end
                default: state_d = ST_UNLOCKED;
            endcase
        end
    end

    always_comb begin
        overflow_d = overflow_q |
                     (data_wr && data_full && !data_pop) |
                     (cmd_wr && cmd_full && !cmd_pop);
        hdr_err_d  = (hdr_inc && hdr_err_q != 16'hFFFF) ? hdr_err_q + 16'd1 : hdr_err_q;
        unk_btf_d  = (unk_inc && unk_btf_q != 16'hFFFF) ? unk_btf_q + 16'd1 : unk_btf_q;
    end

    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_UNLOCKED;
            overflow_q <= 1'b0;
            hdr_err_q  <= '0;
            unk_btf_q  <= '0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
            hdr_err_q  <= hdr_err_d;
            unk_btf_q  <= unk_btf_d;
        end
    end

    aurora_rx_block_sorter_fifo #(.WIDTH(64), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .clk_i     (clk_rx_i),
        .rst_n_i   (rst_n_i),
        .flush_i   (flush),
        .wr_en_i   (data_wr),
        .wr_data_i (rx_data_i),
        .rd_en_i   (data_ready_i && rx_locked_i),
        .rd_data_o (data_o),
        .valid_o   (data_valid_o),
        .full_o    (data_full)
    );

    aurora_rx_block_sorter_fifo #(.WIDTH(56), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk_i     (clk_rx_i),
        .rst_n_i   (rst_n_i),
        .flush_i   (flush),
        .wr_en_i   (cmd_wr),
        .wr_data_i (rx_data_i[55:0]),
        .rd_en_i   (cmd_ready_i && rx_locked_i),
        .rd_data_o (cmd_o),
        .valid_o   (cmd_valid_o),
        .full_o    (cmd_full)
    );

    assign overflow_o    = overflow_q;
    assign hdr_err_cnt_o = hdr_err_q;
    assign unk_btf_cnt_o = unk_btf_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_aurora_rx_block_sorter.sv
// Scoreboard bench for aurora_rx_block_sorter: stimulus pushes expected blocks,
// a negedge monitor pops and compares whenever the DUT hands one over.

module tb_aurora_rx_block_sorter;
    logic        clk_rx_i = 1'b0;
    logic        rst_n_i;
    logic [63:0] rx_data_i;
    logic [1:0]  rx_header_i;
    logic        rx_valid_i;
    logic        rx_locked_i;
    logic [63:0] data_o;
    logic        data_valid_o;
    logic        data_ready_i;
    logic [55:0] cmd_o;
    logic        cmd_valid_o;
    logic        cmd_ready_i;
    logic        overflow_o;
    logic [15:0] hdr_err_cnt_o;
    logic [15:0] unk_btf_cnt_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_data[$];
    logic [55:0] exp_cmd[$];

    aurora_rx_block_sorter dut (
        .clk_rx_i      (clk_rx_i),
        .rst_n_i       (rst_n_i),
        .rx_data_i     (rx_data_i),
        .rx_header_i   (rx_header_i),
        .rx_valid_i    (rx_valid_i),
        .rx_locked_i   (rx_locked_i),
        .data_o        (data_o),
        .data_valid_o  (data_valid_o),
        .data_ready_i  (data_ready_i),
        .cmd_o         (cmd_o),
        .cmd_valid_o   (cmd_valid_o),
        .cmd_ready_i   (cmd_ready_i),
        .overflow_o    (overflow_o),
        .hdr_err_cnt_o (hdr_err_cnt_o),
        .unk_btf_cnt_o (unk_btf_cnt_o),
        .state_o       (state_o)
    );

    always #5 clk_rx_i = ~clk_rx_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_rx_i);
        #1;
    endtask

    task automatic drive_blk(input logic [1:0] h, input logic [63:0] d);
        rx_valid_i  = 1'b1;
        rx_header_i = h;
        rx_data_i   = d;
        tick();
        rx_valid_i  = 1'b0;
    endtask

    // Monitor: a transfer happens at the next edge when valid & ready & locked.
    initial begin
        logic [63:0] ed;
        logic [55:0] ec;
        forever begin
            @(negedge clk_rx_i);
            if (rst_n_i && rx_locked_i) begin
                if (data_valid_o && data_ready_i) begin
                    if (exp_data.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL data_unexpected: got %h required none", data_o);
                    end else begin
                        ed = exp_data.pop_front();
                        chk("data_o", data_o, ed);
                    end
                end
                if (cmd_valid_o && cmd_ready_i) begin
                    if (exp_cmd.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL cmd_unexpected: got %h required none", cmd_o);
                    end else begin
                        ec = exp_cmd.pop_front();
                        chk("cmd_o", {8'h0, cmd_o}, {8'h0, ec});
                    end
                end
            end
        end
    end

    localparam logic [63:0] IDLE_BLK = {8'h78, 56'h0};

    initial begin
        rst_n_i = 1'b0; rx_locked_i = 1'b0; rx_valid_i = 1'b0;
        rx_header_i = 2'b00; rx_data_i = '0; data_ready_i = 1'b0; cmd_ready_i = 1'b0;
        #12;
        chk("rst_data_valid", {63'h0, data_valid_o}, 64'h0);
        chk("rst_cmd_valid", {63'h0, cmd_valid_o}, 64'h0);
        chk("rst_data_o", data_o, 64'h0);
        chk("rst_overflow", {63'h0, overflow_o}, 64'h0);
        chk("rst_hdr_cnt", {48'h0, hdr_err_cnt_o}, 64'h0);
        chk("rst_state", {62'h0, state_o}, 64'h0);
        rst_n_i = 1'b1;
        tick();

        // 1: lock, idle, two data blocks
        rx_locked_i = 1'b1; data_ready_i = 1'b1; cmd_ready_i = 1'b1;
        tick();
        chk("t1_state_wait", {62'h0, state_o}, 64'd1);
        drive_blk(2'b10, IDLE_BLK);
        chk("t1_state_run", {62'h0, state_o}, 64'd2);
        exp_data.push_back(64'h1); exp_data.push_back(64'h2);
        drive_blk(2'b01, 64'h1);
        chk("t1_latency_valid", {63'h0, data_valid_o}, 64'h1);
        drive_blk(2'b01, 64'h2);
        repeat (3) tick();
        chk("t1_drained", {63'h0, data_valid_o}, 64'h0);
        chk("t1_no_cmd", {63'h0, cmd_valid_o}, 64'h0);

        // 2: data before the first idle is discarded
        rx_locked_i = 1'b0; tick();
        chk("t2_state_unlocked", {62'h0, state_o}, 64'd0);
        rx_locked_i = 1'b1; tick();
        drive_blk(2'b01, 64'hA);
        chk("t2_state_wait", {62'h0, state_o}, 64'd1);
        chk("t2_a_dropped", {63'h0, data_valid_o}, 64'h0);
        drive_blk(2'b10, IDLE_BLK);
        chk("t2_state_run", {62'h0, state_o}, 64'd2);
        exp_data.push_back(64'hB);
        drive_blk(2'b01, 64'hB);
        repeat (3) tick();

        // 3: backpressure, 17 blocks into a 16-deep FIFO
        data_ready_i = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            if (i <= 16) exp_data.push_back(64'h100 + 64'(i));
            drive_blk(2'b01, 64'h100 + 64'(i));
        end
        chk("t3_overflow", {63'h0, overflow_o}, 64'h1);
        chk("t3_head_stable", data_o, 64'h101);
        data_ready_i = 1'b1;
        repeat (20) tick();
        chk("t3_drained", {63'h0, data_valid_o}, 64'h0);
        chk("t3_all_seen", 64'(exp_data.size()), 64'd0);

        // 3b: write into a full FIFO with a pop in the same cycle is kept
        data_ready_i = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            exp_data.push_back(64'h200 + 64'(i));
            drive_blk(2'b01, 64'h200 + 64'(i));
        end
        data_ready_i = 1'b1;
        exp_data.push_back(64'h211);
        drive_blk(2'b01, 64'h211);
        repeat (20) tick();
        chk("t3b_all_seen", 64'(exp_data.size()), 64'd0);

        // 4: sorting and error counting
        exp_cmd.push_back(56'h00112233445566);
        drive_blk(2'b10, {8'hD2, 56'h00112233445566});
        drive_blk(2'b10, {8'h55, 56'hDEAD});
        drive_blk(2'b00, 64'h1234);
        drive_blk(2'b11, 64'h5678);
        drive_blk(2'b10, IDLE_BLK);
        repeat (3) tick();
        chk("t4_unk_cnt", {48'h0, unk_btf_cnt_o}, 64'd1);
        chk("t4_hdr_cnt", {48'h0, hdr_err_cnt_o}, 64'd2);
        chk("t4_cmd_seen", 64'(exp_cmd.size()), 64'd0);

        // 5: lock loss flushes queued entries
        data_ready_i = 1'b0; cmd_ready_i = 1'b0;
        drive_blk(2'b01, 64'h501);
        drive_blk(2'b01, 64'h502);
        drive_blk(2'b10, {8'hD2, 56'h503});
        chk("t5_queued", {62'h0, data_valid_o, cmd_valid_o}, 64'h3);
        rx_locked_i = 1'b0; data_ready_i = 1'b1; cmd_ready_i = 1'b1;
        drive_blk(2'b01, 64'h504);
        chk("t5_flushed", {62'h0, data_valid_o, cmd_valid_o}, 64'h0);
        chk("t5_state", {62'h0, state_o}, 64'd0);
        chk("t5_counters_kept", {31'h0, overflow_o, unk_btf_cnt_o, hdr_err_cnt_o}, {31'h0, 1'b1, 16'd1, 16'd2});
        rx_locked_i = 1'b1; tick();
        drive_blk(2'b01, 64'h505);
        tick();
        chk("t5_needs_idle", {62'h0, state_o, data_valid_o}, {62'h0, 2'd1, 1'b0});
        drive_blk(2'b10, IDLE_BLK);
        chk("t5_relocked", {62'h0, state_o}, 64'd2);

        // 6: saturation, then asynchronous reset mid-stream
        rx_valid_i = 1'b1; rx_header_i = 2'b00; rx_data_i = 64'h0;
        repeat (70000) @(posedge clk_rx_i);
        #1 rx_valid_i = 1'b0;
        chk("t6_saturated", {48'h0, hdr_err_cnt_o}, 64'hFFFF);
        data_ready_i = 1'b0;
        drive_blk(2'b01, 64'h601);
        drive_blk(2'b01, 64'h602);
        chk("t6_pre_reset_valid", {63'h0, data_valid_o}, 64'h1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("t6_async_outputs", {data_o[31:0], 10'h0, data_valid_o, cmd_valid_o, overflow_o, 1'b0, state_o},
            64'h0);
        chk("t6_async_cnts", {32'h0, hdr_err_cnt_o, unk_btf_cnt_o}, 64'h0);
        exp_data.delete(); exp_cmd.delete();
        tick();
        rst_n_i = 1'b1;
        repeat (3) tick();
        chk("t6_after_release", {61'h0, state_o, data_valid_o}, {61'h0, 2'd1, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
